// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - playfield geometry, piece ids, spawn rows and settle FSM states
package tetris_pkg;

    localparam int MAP_W = 8;
    localparam int MAP_H = 16;

    localparam logic [2:0] ID_I = 3'd0;
    localparam logic [2:0] ID_O = 3'd1;
    localparam logic [2:0] ID_Z = 3'd2;
    localparam logic [2:0] ID_S = 3'd3;
    localparam logic [2:0] ID_L = 3'd4;
    localparam logic [2:0] ID_J = 3'd5;
    localparam logic [2:0] ID_T = 3'd6;

    typedef enum logic [2:0] {
        ST_SPAWN,
        ST_SETTLE,
        ST_CHECK,
        ST_FALL,
        ST_LOCK,
        ST_CLEAR,
        ST_OVER
    } state_t;

    // Element [0] is cell 1, element [3] is cell 4.
    typedef logic [3:0][3:0] piece_y_t;

    function automatic piece_y_t spawn_y(input logic [2:0] id);
        piece_y_t y;
        case (id)
            ID_O, ID_Z: y = {4'd1, 4'd1, 4'd0, 4'd0};
            ID_S:       y = {4'd0, 4'd0, 4'd1, 4'd1};
            ID_L:       y = {4'd0, 4'd1, 4'd1, 4'd1};
            ID_J:       y = {4'd1, 4'd1, 4'd1, 4'd0};
            ID_T:       y = {4'd1, 4'd0, 4'd0, 4'd1};
            default:    y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gravity_timer.sv
// rtl/gravity_timer.sv - free-running fall counter, pulses tick on wrap, cleared while disabled
module gravity_timer #(
    parameter int GRAVITY_TICKS = 12_500_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(GRAVITY_TICKS);
    localparam logic [CW-1:0] LAST = CW'(GRAVITY_TICKS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/drop_lock_clear.sv
// rtl/drop_lock_clear.sv - piece gravity, soft drop, landing, playfield merge, row clear and spawn
module drop_lock_clear
    import tetris_pkg::*;
#(
    parameter int GRAVITY_TICKS = 12_500_000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         left_button,
    input  logic         right_button,
    input  logic         down_button,
    input  logic [2:0]   next_id,
    input  logic [2:0]   block1_x,
    input  logic [2:0]   block2_x,
    input  logic [2:0]   block3_x,
    input  logic [2:0]   block4_x,
    output logic [3:0]   block1_y,
    output logic [3:0]   block2_y,
    output logic [3:0]   block3_y,
    output logic [3:0]   block4_y,
    output logic [127:0] map,
    output logic         placed,
    output logic [2:0]   new_block_id,
    output logic [7:0]   lines,
    output logic         game_over
);

    state_t         state_q, state_d;
    piece_y_t       y_q, y_d;
    logic [127:0]   map_q, map_d;
    logic [7:0]     lines_q, lines_d;
    logic           placed_q, placed_d;
    logic           game_over_q, game_over_d;
    logic           pending_q, pending_d;
    logic [2:0]     id_q, id_d;
    logic [3:0]     row_q, row_d;

    logic [3:0][2:0] x;
    logic [127:0]   piece_mask;
    logic [127:0]   clr_mask;
    logic [127:0]   map_shift;
    logic [6:0]     shamt;
    logic           occupied;
    logic           blocked;
    logic           row_full;
    logic           fall_en;
    logic           tick;
    logic           step_req;
    logic           lateral;

    assign x        = {block4_x, block3_x, block2_x, block1_x};
    assign fall_en  = (state_q == ST_FALL);
    assign step_req = tick | down_button;
    assign lateral  = left_button | right_button;

    gravity_timer #(
        .GRAVITY_TICKS (GRAVITY_TICKS)
    ) u_gravity (
        .CLK  (CLK),
        .RST  (RST),
        .en   (fall_en),
        .tick (tick)
    );

    // Cell index is simply {y, x} because the playfield is 8 columns wide.
    always_comb begin
        piece_mask = '0;
        occupied   = 1'b0;
        blocked    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            piece_mask[{y_q[i], x[i]}] = 1'b1;
            occupied = occupied | map_q[{y_q[i], x[i]}];
            if (y_q[i] == 4'(MAP_H - 1)) begin
                blocked = 1'b1;
            end else if (map_q[{4'(y_q[i] + 4'd1), x[i]}]) begin
                blocked = 1'b1;
            end
        end
    end

    // Rows 0..row_q move down by one; rows below row_q are untouched.
    always_comb begin
        row_full  = &map_q[{row_q, 3'b000} +: MAP_W];
        shamt     = {4'(4'd15 - row_q), 3'b000};
        clr_mask  = {128{1'b1}} >> shamt;
        map_shift = ((map_q << 8) & clr_mask) | (map_q & ~clr_mask);
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        map_d       = map_q;
        lines_d     = lines_q;
        placed_d    = 1'b0;
        game_over_d = game_over_q;
        pending_d   = pending_q;
        id_d        = id_q;
        row_d       = row_q;
        case (state_q)
            ST_SPAWN: begin
                id_d      = (next_id == 3'd7) ? ID_I : next_id;
                y_d       = spawn_y(next_id);
                placed_d  = 1'b1;
                pending_d = 1'b0;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (occupied) begin
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else begin
                    state_d = ST_FALL;
                end
            end
            ST_FALL: begin
                // A step coinciding with a lateral move waits one cycle so x and y never change together.
                if (pending_q || (step_req && !lateral)) begin
                    pending_d = 1'b0;
                    if (blocked) begin
                        state_d = ST_LOCK;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            y_d[i] = y_q[i] + 4'd1;
                        end
                    end
                end else if (step_req) begin
                    pending_d = 1'b1;
                end
            end
            ST_LOCK: begin
                map_d   = map_q | piece_mask;
                row_d   = 4'd15;
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (row_full) begin
                    map_d   = map_shift;
                    lines_d = lines_q + 8'd1;
                end else if (row_q == 4'd0) begin
                    state_d = ST_SPAWN;
                end else begin
                    row_d = row_q - 4'd1;
                end
            end
            ST_OVER: begin
                game_over_d = 1'b1;
            end
            default: begin
                state_d = ST_SPAWN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_SPAWN;
            y_q         <= '0;
            map_q       <= '0;
            lines_q     <= '0;
            placed_q    <= 1'b0;
            game_over_q <= 1'b0;
            pending_q   <= 1'b0;
            id_q        <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            map_q       <= map_d;
            lines_q     <= lines_d;
            placed_q    <= placed_d;
            game_over_q <= game_over_d;
            pending_q   <= pending_d;
            id_q        <= id_d;
            row_q       <= row_d;
        end
    end

    assign block1_y     = y_q[0];
    assign block2_y     = y_q[1];
    assign block3_y     = y_q[2];
    assign block4_y     = y_q[3];
    assign map          = map_q;
    assign placed       = placed_q;
    assign new_block_id = id_q;
    assign lines        = lines_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_drop_lock_clear.sv
// tb/tb_drop_lock_clear.sv - scoreboard bench for drop_lock_clear with directed piece sequences
module tb_drop_lock_clear;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         left_button = 1'b0;
    logic         right_button = 1'b0;
    logic         down_button = 1'b0;
    logic [2:0]   next_id = 3'd7;
    logic [2:0]   block1_x = 3'd0;
    logic [2:0]   block2_x = 3'd1;
    logic [2:0]   block3_x = 3'd2;
    logic [2:0]   block4_x = 3'd3;
    logic [3:0]   block1_y, block2_y, block3_y, block4_y;
    logic [127:0] map;
    logic         placed;
    logic [2:0]   new_block_id;
    logic [7:0]   lines;
    logic         game_over;

    drop_lock_clear #(
        .GRAVITY_TICKS (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .left_button  (left_button),
        .right_button (right_button),
        .down_button  (down_button),
        .next_id      (next_id),
        .block1_x     (block1_x),
        .block2_x     (block2_x),
        .block3_x     (block3_x),
        .block4_x     (block4_x),
        .block1_y     (block1_y),
        .block2_y     (block2_y),
        .block3_y     (block3_y),
        .block4_y     (block4_y),
        .map          (map),
        .placed       (placed),
        .new_block_id (new_block_id),
        .lines        (lines),
        .game_over    (game_over)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]   id;
        logic [15:0]  ys;
        logic [127:0] map;
        logic [7:0]   lines;
        int           gap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   placed_seen = 0;
    int   last_cyc = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [2:0] id, input logic [15:0] ys,
                            input logic [127:0] m, input logic [7:0] l, input int gap);
        exp_t e;
        e.id = id; e.ys = ys; e.map = m; e.lines = l; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_placed(input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while (!placed && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (!placed) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_%s: no placed within 400 cycles", tag);
        end
    endtask

    task automatic set_x(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
        block1_x = a; block2_x = b; block3_x = c; block4_x = d;
    endtask

    function automatic logic [127:0] stack_map(input int rows);
        logic [127:0] m;
        m = '0;
        for (int r = 0; r < rows; r++) m = m | (128'h0F << (8 * (15 - r)));
        return m;
    endfunction

    // Monitor: every spawn pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                last_cyc = -1;
            end else if (placed) begin
                placed_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_placed: got placed at cycle %0d required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("spawn_id", new_block_id, e.id);
                    check("spawn_y", {block4_y, block3_y, block2_y, block1_y}, e.ys);
                    check("spawn_map", map, e.map);
                    check("spawn_lines", lines, e.lines);
                    if (e.gap != 0 && last_cyc >= 0) check("placed_gap", cyc - last_cyc, e.gap);
                end
                last_cyc = cyc;
                @(negedge CLK);
                if (!RST) check("placed_width", placed, 1'b0);
            end
        end
    end

    initial begin
        repeat (30000) @(posedge CLK);
        vectors++;
        miscompares++;
        $display("FAIL watchdog: simulation exceeded 30000 cycles");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int n;
        logic [2:0]  rid [5];
        logic [15:0] rys [5];
        rid = '{3'd6, 3'd2, 3'd3, 3'd4, 3'd5};
        rys = '{16'h1001, 16'h1100, 16'h0011, 16'h0111, 16'h1110};

        push_exp(3'd0, 16'h0000, '0, 8'd0, 0);
        repeat (3) @(negedge CLK);
        check("rst_map", map, '0);
        check("rst_lines", lines, 8'd0);
        check("rst_placed", placed, 1'b0);
        check("rst_game_over", game_over, 1'b0);
        check("rst_id", new_block_id, 3'd0);
        check("rst_y", {block4_y, block3_y, block2_y, block1_y}, 16'h0000);
        RST = 1'b0;

        // I piece (id 7 aliases to I) falls the full height.
        wait_placed("p1");
        next_id = 3'd0;
        push_exp(3'd0, 16'h0000, 128'h0F << 120, 8'd0, 84);
        n = 0;
        while (block1_y != 4'd15 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("p1_cycles_to_y15", n, 62);

        wait_placed("p2");
        set_x(3'd4, 3'd5, 3'd6, 3'd7);
        push_exp(3'd0, 16'h0000, '0, 8'd1, 85);

        wait_placed("p3");
        set_x(3'd0, 3'd1, 3'd2, 3'd3);
        push_exp(3'd0, 16'h0000, 128'h0F << 120, 8'd1, 80);
        repeat (5) @(negedge CLK);
        down_button = 1'b1;
        @(negedge CLK);
        check("down_with_tick", block1_y, 4'd1);
        @(negedge CLK);
        down_button = 1'b0;
        check("down_alone", block1_y, 4'd2);
        repeat (3) @(negedge CLK);
        check("tick_after_down", block1_y, 4'd3);

        wait_placed("p4");
        set_x(3'd4, 3'd5, 3'd6, 3'd7);
        next_id = 3'd1;
        push_exp(3'd1, 16'h1100, '0, 8'd2, 85);
        repeat (5) @(negedge CLK);
        right_button = 1'b1;
        @(negedge CLK);
        right_button = 1'b0;
        check("deferred_hold", block1_y, 4'd0);
        @(negedge CLK);
        check("deferred_step", block1_y, 4'd1);

        // Four O pieces fill rows 14 and 15; the last clears both at once.
        wait_placed("o1");
        set_x(3'd0, 3'd1, 3'd0, 3'd1);
        push_exp(3'd1, 16'h1100, 128'h0303 << 112, 8'd2, 80);
        wait_placed("o2");
        set_x(3'd2, 3'd3, 3'd2, 3'd3);
        push_exp(3'd1, 16'h1100, 128'h0F0F << 112, 8'd2, 80);
        wait_placed("o3");
        set_x(3'd4, 3'd5, 3'd4, 3'd5);
        push_exp(3'd1, 16'h1100, 128'h3F3F << 112, 8'd2, 80);
        wait_placed("o4");
        set_x(3'd6, 3'd7, 3'd6, 3'd7);
        next_id = 3'd0;
        push_exp(3'd0, 16'h0000, '0, 8'd4, 82);

        // Stack I pieces in columns 0..3 until the spawn cells are blocked.
        for (int j = 1; j <= 17; j++) begin
            wait_placed("stack");
            set_x(3'd0, 3'd1, 3'd2, 3'd3);
            if (j < 17) push_exp(3'd0, 16'h0000, stack_map(j), 8'd4, 0);
        end
        repeat (3) @(negedge CLK);
        check("game_over_set", game_over, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            down_button  = (i % 2) == 0;
            left_button  = (i % 5) == 1;
            right_button = (i % 7) == 3;
        end
        @(negedge CLK);
        down_button = 1'b0; left_button = 1'b0; right_button = 1'b0;
        check("over_placed_count", placed_seen, 25);
        check("over_map_frozen", map, {16{8'h0F}});
        check("over_lines_frozen", lines, 8'd4);
        check("over_y_frozen", {block4_y, block3_y, block2_y, block1_y}, 16'h0000);

        RST = 1'b1;
        @(negedge CLK);
        check("rst2_map", map, '0);
        check("rst2_game_over", game_over, 1'b0);
        check("rst2_lines", lines, 8'd0);
        check("rst2_placed", placed, 1'b0);

        // Spawn table for the remaining ids, one reset per piece.
        for (int k = 0; k < 5; k++) begin
            next_id = rid[k];
            push_exp(rid[k], rys[k], '0, 8'd0, 0);
            RST = 1'b0;
            wait_placed("table");
            RST = 1'b1;
            repeat (2) @(negedge CLK);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/drop_lock_clear.md
# drop_lock_clear

Vertical-motion and settling stage of the 8×16 dot-matrix Tetris core, directly downstream of `left_right_move`. Consumes the falling piece's x coordinates, owns its y coordinates, applies gravity and soft drop, detects landing, merges the piece into the 128-bit playfield, clears full rows, and spawns the next piece by pulsing `placed` to the lateral-move stage.

## Interface
- `GRAVITY_TICKS`, default 12_500_000 — clocks between automatic one-row fall steps; minimum 2.
- `CLK` in 1 — system clock.
- `RST` in 1 — synchronous, active-high reset.
- `left_button`, `right_button` in 1 each — same single-cycle pulses delivered to `left_right_move`.
- `down_button` in 1 — soft-drop pulse, one cycle per press.
- `next_id` in 3 — id of the next piece (0 I, 1 O, 2 Z, 3 S, 4 L, 5 J, 6 T); 7 is treated as 0.
- `block1_x`..`block4_x` in 3 each — current piece x, from `left_right_move`.
- `block1_y`..`block4_y` out 4 each — current piece y; 0 = top row, 15 = bottom row.
- `map` out 128 — settled cells; bit index = x + 8·y.
- `placed` out 1 — one-cycle spawn pulse, registered.
- `new_block_id` out 3 — id of the piece being spawned; valid while `placed` is 1, held afterwards.
- `lines` out 8 — total rows cleared; wraps 255→0.
- `game_over` out 1 — sticky until `RST`.

## Operation
- Spawn y table, cells 1..4, pairing with the move stage's spawn x:
  - I 0,0,0,0
  - O 0,0,1,1
  - Z 0,0,1,1
  - S 1,1,0,0
  - L 1,1,1,0
  - J 0,1,1,1
  - T 1,0,0,1
- FSM states: SPAWN, SETTLE, CHECK, FALL, LOCK, CLEAR, OVER.
- SPAWN, 1 cycle: latch `next_id` into `new_block_id`, load the spawn y values, assert `placed`, then go to SETTLE.
- SETTLE, 1 cycle: wait for the move stage to load the new x values; go to CHECK.
- CHECK, 1 cycle: if any piece cell is already set in `map`, go to OVER; otherwise go to FALL and clear the gravity counter.
- FALL step request:
  - Raised by a gravity tick, `down_button`, or both in the same cycle; a coincident tick and press produce one step only.
  - If `left_button` or `right_button` is high in the request cycle, the step is held pending and executed in the next cycle without either button. This prevents a diagonal overlap caused by simultaneous x and y updates.
- FALL step execution:
  - Blocked if any cell has y==15 or `map[x+8·(y+1)]` set; blocked goes to LOCK.
  - Otherwise all four y values increment together.
- LOCK, 1 cycle: set the four piece bits in `map`, then go to CLEAR with row pointer r=15.
- CLEAR scans one row per cycle:
  - If row r is full (8 ones), rows 0..r-1 shift down one row, row 0 becomes zero, `lines` increments, and r is rescanned.
  - Otherwise r decrements.
  - After r=0 is processed, go to SPAWN.
- OVER:
  - `map`, y values, and `lines` are frozen; `placed` stays 0; `game_over` is 1.
  - Buttons are ignored.
- Buttons and ticks outside FALL are ignored; the gravity counter is held at 0.

## Timing
- Reset values:
  - `map`=0, `lines`=0, `placed`=0, `game_over`=0, `new_block_id`=0, all y=0.
  - Next state is SPAWN, with the first `placed` in the cycle after reset deasserts.
- `placed` high for exactly one cycle per piece; x is valid two cycles after `placed` rises, and the spawn collision check uses those values.
- Fall step: y updates at the edge after the request, or one cycle later if deferred.
- Gravity tick: counter 0..GRAVITY_TICKS-1; the tick fires on wrap.
- Landing to next `placed`: 1 (LOCK) + 16 + (number of cleared rows) + 1 cycles.
- `RST` mid-operation, including in OVER or mid-CLEAR, returns everything to reset values on that edge.

## Structure
- `tetris_pkg` holds:
  - `MAP_W`=8, `MAP_H`=16, and the piece-id constants.
  - A spawn-y lookup function indexed by id.
  - The FSM state enum.
- Sub-module `gravity_timer` (parameter `GRAVITY_TICKS`; ports `CLK`, `RST`, `en`, `tick`) is the free counter; it clears when `en`=0.

## Test plan
- Reset, then leave `next_id`=0 → `placed` pulses once and y=0,0,0,0. With x=0..3 and GRAVITY_TICKS=4, the piece reaches y=15 after 15 ticks, `map[127:120]` becomes 8'h0F, and a new `placed` follows.
- Preload row 15 = 8'hF0 by landing two pieces, then land an I at x=0..3 → row 15 is cleared, `map`=0, and `lines`=1.
- `down_button` coincident with a gravity tick → y advances by exactly 1.
- `right_button` in the same cycle as a gravity tick → y updates one cycle later, and no piece cell overlaps `map`.
- Fill column cells so that spawn cells (0,0)..(3,0) are occupied → CHECK enters OVER, `game_over`=1, and `placed` never rises again. Then assert `RST` → `map`=0 and `game_over`=0.
- Two full rows, 14 and 15, cleared at one lock → `lines` increases by 2 and landing-to-`placed` takes 20 cycles.
